uart_rx_framed: RTL and testbench

//  Parametrised UART receiver, successor to the single-mode receiver. Samples async rx,

---
 rtl/uart_rx_framed_if.sv | 20 ++
 rtl/uart_rx_framed.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_framed_if.sv
// Beat stream from the UART receiver to downstream packet logic.
interface uart_rx_framed_if #(
  parameter int unsigned W_OUT = 32
) ();
  logic             m_valid;
  logic             m_ready;
  logic [W_OUT-1:0] m_data;
  logic             m_parity_err;
  logic             m_frame_err;

  modport master (
    output m_valid, m_data, m_parity_err, m_frame_err,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_parity_err, m_frame_err,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_framed.sv
// Framed UART receiver: synchronises rx, decodes start/data/parity/stop, packs
// W_OUT/BITS_PER_WORD characters per beat and queues beats in a small FIFO.
// Optional 2-of-3 majority sampling enabled by defining UART_RX_MAJORITY_VOTE_EN.
module uart_rx_framed #(
  parameter int unsigned CLOCKS_PER_PULSE = 16,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned W_OUT            = 32,
  parameter int unsigned PARITY_MODE      = 1,
  parameter int unsigned STOP_BITS        = 1,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  uart_rx_framed_if.master m,
  output logic             overrun
);
  localparam int unsigned NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int unsigned CW   = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int unsigned BW   = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int unsigned WW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned EW   = W_OUT + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d, rxs_q, rxs_d;
  logic [CW-1:0]        c_clocks_q, c_clocks_d;
  logic [BW-1:0]        c_bits_q, c_bits_d;
  logic [WW-1:0]        c_words_q, c_words_d;
  logic [BITS_PER_WORD-1:0] char_q, char_d;
  logic                 char_perr_q, char_perr_d, char_ferr_q, char_ferr_d;
  logic                 perr_acc_q, perr_acc_d, ferr_acc_q, ferr_acc_d;
  logic [W_OUT-1:0]     beat_q, beat_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0]      count_q, count_d;
  logic                 m_valid_q, m_valid_d, overrun_q, overrun_d;
  logic [EW-1:0]        head_q, head_d;
  logic                 bit_c, ferr_now_c, push_c, push_ok_c, pop_c, full_c;
  logic [EW-1:0]        push_entry_c;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q, hist_d;

  // Two previous rxs samples, for majority decisions at T-2, T-1, T.
  always_comb hist_d = {hist_q[0], rxs_q};

  // History register.
  always_ff @(posedge clk) begin
    if (!rstn) hist_q <= 2'b11;
    else       hist_q <= hist_d;
  end

  assign bit_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
  assign bit_c = rxs_q;
`endif

  // Receive FSM, beat assembly and FIFO next-state.
  always_comb begin
    state_d      = state_q;
    rx_meta_d    = rx;
    rxs_d        = rx_meta_q;
    c_clocks_d   = c_clocks_q;
    c_bits_d     = c_bits_q;
    c_words_d    = c_words_q;
    char_d       = char_q;
    char_perr_d  = char_perr_q;
    char_ferr_d  = char_ferr_q;
    perr_acc_d   = perr_acc_q;
    ferr_acc_d   = ferr_acc_q;
    beat_d       = beat_q;
    mem_d        = mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    overrun_d    = 1'b0;
    push_c       = 1'b0;
    push_entry_c = '0;
    ferr_now_c   = char_ferr_q | ~bit_c;

    case (state_q)
      S_IDLE: begin
        c_clocks_d = '0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        if (c_clocks_q == CW'(CLOCKS_PER_PULSE / 2 - 1)) begin
          c_clocks_d = '0;
          if (!bit_c) begin
            state_d     = S_DATA;
            c_bits_d    = '0;
            char_perr_d = 1'b0;
            char_ferr_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          c_clocks_d = c_clocks_q + CW'(1);
        end
      end
      S_DATA: begin
        if (c_clocks_q == CW'(CLOCKS_PER_PULSE - 1)) begin
          c_clocks_d = '0;
          char_d     = BITS_PER_WORD'({bit_c, char_q} >> 1);
          if (c_bits_q == BW'(BITS_PER_WORD - 1)) begin
            c_bits_d = '0;
            state_d  = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
          end else begin
            c_bits_d = c_bits_q + BW'(1);
          end
        end else begin
          c_clocks_d = c_clocks_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (c_clocks_q == CW'(CLOCKS_PER_PULSE - 1)) begin
          c_clocks_d  = '0;
          char_perr_d = (PARITY_MODE == 2) ? ~(^{char_q, bit_c}) : (^{char_q, bit_c});
          state_d     = S_STOP;
        end else begin
          c_clocks_d = c_clocks_q + CW'(1);
        end
      end
      S_STOP: begin
        if (c_clocks_q == CW'(CLOCKS_PER_PULSE - 1)) begin
          c_clocks_d = '0;
          if (c_bits_q == BW'(STOP_BITS - 1)) begin
            c_bits_d = '0;
            for (int i = 0; i < NUM_WORDS; i++)
              if (c_words_q == WW'(i)) beat_d[i*BITS_PER_WORD +: BITS_PER_WORD] = char_q;
            perr_acc_d = perr_acc_q | char_perr_q;
            ferr_acc_d = ferr_acc_q | ferr_now_c;
            if (c_words_q == WW'(NUM_WORDS - 1)) begin
              push_c       = 1'b1;
              push_entry_c = {ferr_acc_d, perr_acc_d, beat_d};
              c_words_d    = '0;
              perr_acc_d   = 1'b0;
              ferr_acc_d   = 1'b0;
              beat_d       = '0;
            end else begin
              c_words_d = c_words_q + WW'(1);
            end
            state_d = ferr_now_c ? S_WAIT_HIGH : S_IDLE;
          end else begin
            c_bits_d    = c_bits_q + BW'(1);
            char_ferr_d = ferr_now_c;
          end
        end else begin
          c_clocks_d = c_clocks_q + CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // FIFO: a push into a full FIFO only succeeds when the head pops this cycle.
    pop_c     = m_valid_q && m.m_ready;
    full_c    = (count_q == CNTW'(FIFO_DEPTH));
    push_ok_c = push_c && (!full_c || pop_c);
    overrun_d = push_c && full_c && !pop_c;
    if (push_ok_c) begin
      mem_d[wptr_q] = push_entry_c;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop_c) rptr_d = rptr_q + AW'(1);
    count_d   = count_q + CNTW'(push_ok_c) - CNTW'(pop_c);
    m_valid_d = (count_d != '0);
    if (count_d == '0)                       head_d = '0;
    else if (push_ok_c && wptr_q == rptr_d)  head_d = push_entry_c;
    else                                     head_d = mem_q[rptr_d];
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      c_clocks_q  <= '0;
      c_bits_q    <= '0;
      c_words_q   <= '0;
      char_q      <= '0;
      char_perr_q <= 1'b0;
      char_ferr_q <= 1'b0;
      perr_acc_q  <= 1'b0;
      ferr_acc_q  <= 1'b0;
      beat_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      m_valid_q   <= 1'b0;
      overrun_q   <= 1'b0;
      head_q      <= '0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      c_clocks_q  <= c_clocks_d;
      c_bits_q    <= c_bits_d;
      c_words_q   <= c_words_d;
      char_q      <= char_d;
      char_perr_q <= char_perr_d;
      char_ferr_q <= char_ferr_d;
      perr_acc_q  <= perr_acc_d;
      ferr_acc_q  <= ferr_acc_d;
      beat_q      <= beat_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      m_valid_q   <= m_valid_d;
      overrun_q   <= overrun_d;
      head_q      <= head_d;
    end
  end

  assign m.m_valid      = m_valid_q;
  assign m.m_data       = head_q[W_OUT-1:0];
  assign m.m_parity_err = head_q[W_OUT];
  assign m.m_frame_err  = head_q[W_OUT+1];
  assign overrun        = overrun_q;
endmodule

// File: tb/tb_uart_rx_framed.sv
// Randomised self-checking bench for uart_rx_framed (16-bit beats, even parity, 1 stop).
module tb_uart_rx_framed;
  localparam int CPP   = 16;
  localparam int BPW   = 8;
  localparam int WOUT  = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx = 1'b1;
  logic overrun;

  uart_rx_framed_if #(.W_OUT(WOUT)) bus ();

  uart_rx_framed #(
    .CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(BPW), .W_OUT(WOUT),
    .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .m(bus.master), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_seen = 0;
  int exp_ovr  = 0;
  bit stall_mode = 1'b0;
  bit rand_ready = 1'b0;

  // Reference model: expected beats as {ferr, perr, data}
  logic [WOUT+1:0] exp_q [$];
  logic [WOUT-1:0] mdl_beat = '0;
  int              mdl_slot = 0;
  bit              mdl_perr = 1'b0, mdl_ferr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mdl_beat = '0; mdl_slot = 0; mdl_perr = 1'b0; mdl_ferr = 1'b0;
  endtask

  task automatic model_char(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    mdl_beat[mdl_slot*BPW +: BPW] = d;
    mdl_perr |= bad_par;
    mdl_ferr |= bad_stop;
    mdl_slot++;
    if (mdl_slot == WOUT / BPW) begin
      if (stall_mode && exp_q.size() == DEPTH) exp_ovr++;
      else exp_q.push_back({mdl_ferr, mdl_perr, mdl_beat});
      model_reset();
    end
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    repeat (CPP) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                           input int low_extra);
    bit_out(1'b0);
    for (int i = 0; i < BPW; i++) bit_out(d[i]);
    bit_out((^d) ^ bad_par);
    model_char(d, bad_par, bad_stop);
    bit_out(!bad_stop);
    if (low_extra > 0) begin
      rx = 1'b0;
      repeat (low_extra) @(negedge clk);
    end
    bit_out(1'b1);
    bit_out(1'b1);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus.m_ready = v;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: compare every accepted beat, count overrun pulses, check stall stability
  logic            prev_vld = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b0;
  logic [WOUT+1:0] prev_beat = '0;
  always @(negedge clk) begin
    if (rstn && prev_rst && prev_vld && !prev_rdy) begin
      check("stall_valid", 32'(bus.m_valid), 32'd1);
      check("stall_data", 32'({bus.m_frame_err, bus.m_parity_err, bus.m_data}), 32'(prev_beat));
    end
    if (rstn && overrun) ovr_seen++;
    if (rstn && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(bus.m_data), 32'hFFFF_FFFF);
      end else begin
        logic [WOUT+1:0] e;
        e = exp_q.pop_front();
        check("beat_data", 32'(bus.m_data), 32'(e[WOUT-1:0]));
        check("beat_perr", 32'(bus.m_parity_err), 32'(e[WOUT]));
        check("beat_ferr", 32'(bus.m_frame_err), 32'(e[WOUT+1]));
      end
    end
    prev_vld  = bus.m_valid;
    prev_rdy  = bus.m_ready;
    prev_rst  = rstn;
    prev_beat = {bus.m_frame_err, bus.m_parity_err, bus.m_data};
  end

  // Random backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1 if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
    end
  end

  // Watchdog
  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr_before;
    bus.m_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_data", 32'(bus.m_data), 32'd0);
    check("rst_errs", 32'({bus.m_parity_err, bus.m_frame_err}), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rstn = 1'b1;
    bit_out(1'b1);

    // Clean beat
    send_char(8'hA5, 0, 0, 0);
    send_char(8'h3C, 0, 0, 0);
    wait_drain("t1_drain");

    // Parity error on second character
    send_char(8'hA5, 0, 0, 0);
    send_char(8'h3C, 1, 0, 0);
    wait_drain("t2_drain");

    // Framing error followed by a long break
    send_char(8'hA5, 0, 1, 40);
    send_char(8'h3C, 0, 0, 0);
    wait_drain("t3_drain");

    // Short start glitch is rejected
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPP) @(negedge clk);
    check("t4_no_valid", 32'(bus.m_valid), 32'd0);
    send_char(8'h96, 0, 0, 0);
    send_char(8'h0F, 0, 0, 0);
    wait_drain("t4_drain");

    // FIFO overrun under backpressure, then ordered drain
    set_ready(1'b0);
    stall_mode = 1'b1;
    ovr_before = ovr_seen;
    for (int b = 0; b < 5; b++) begin
      send_char(8'($urandom), 0, 0, 0);
      send_char(8'($urandom), 0, 0, 0);
    end
    check("t5_overrun_once", 32'(ovr_seen - ovr_before), 32'd1);
    check("t5_model_ovr", 32'(exp_ovr), 32'd1);
    check("t5_valid_held", 32'(bus.m_valid), 32'd1);
    stall_mode = 1'b0;
    set_ready(1'b1);
    wait_drain("t5_drain");
    repeat (2) @(negedge clk);
    check("t5_empty", 32'(bus.m_valid), 32'd0);

    // Reset mid-DATA discards the partial beat
    send_char(8'h11, 0, 0, 0);
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(1'b1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    rx = 1'b1;
    model_reset();
    @(negedge clk);
    check("t6_valid", 32'(bus.m_valid), 32'd0);
    check("t6_data", 32'(bus.m_data), 32'd0);
    repeat (3 * CPP) @(negedge clk);
    check("t6_no_valid", 32'(bus.m_valid), 32'd0);
    send_char(8'h5A, 0, 0, 0);
    send_char(8'hC3, 0, 0, 0);
    wait_drain("t6_drain");

    // Random characters, random errors, random backpressure
    rand_ready = 1'b1;
    ovr_before = ovr_seen;
    for (int b = 0; b < 24; b++)
      send_char(8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 0);
    wait_drain("rand_drain");
    rand_ready = 1'b0;
    set_ready(1'b1);
    check("rand_no_overrun", 32'(ovr_seen - ovr_before), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
